// File: rtl/display_scan_decoder.sv
// Recovers the digits shown on a multiplexed 4-digit 7-segment display. The scan lines are
// synchronised, each digit/segment pair is debounced, and the result is decoded and checked.
//
// state       | meaning
// ------------+-----------------------------------------------------------------
// IDLE        | no single digit selected, nothing pending
// WAIT_STABLE | a digit/pattern pair is being counted toward STABLE_CYC
// CAPTURED    | current pair already captured, waiting for it to change
module display_scan_decoder #(
    parameter int         STABLE_CYC  = 4,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter logic [3:0] DIG_MASK    = 4'b1111
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       DG1,
    input  logic       DG2,
    input  logic       DG3,
    input  logic       DG4,
    input  logic [6:0] SEG_IN,
    output logic [3:0] DIG1,
    output logic [3:0] DIG2,
    output logic [3:0] DIG3,
    output logic [3:0] DIG4,
    output logic [3:0] DIG_VLD,
    output logic [6:0] SEC_BIN,
    output logic       SEC_OK,
    output logic       FRAME_DONE,
    output logic       SEG_ERR,
    output logic       STALE
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STABLE,
        CAPTURED
    } state_t;

    localparam logic [3:0]  STABLE_LIM  = 4'(STABLE_CYC);
    localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_CYC);
    localparam logic [3:0]  CODE_BLANK  = 4'hF;
    localparam logic [3:0]  CODE_ERR    = 4'hE;

    logic [3:0]      dg_s1;
    logic [3:0]      dg_s2;
    logic [6:0]      seg_s1;
    logic [6:0]      seg_s2;

    state_t          state;
    logic [3:0]      stab_cnt;
    logic [1:0]      cur_idx;
    logic [6:0]      cur_pat;

    logic [3:0][3:0] dig;
    logic [3:0]      dig_vld;
    logic [3:0]      frame_bits;
    logic [19:0]     tmo_cnt;
    logic            cap_d;
    logic [6:0]      sec_bin;
    logic            sec_ok;
    logic            frame_done;
    logic            seg_err;
    logic            stale;

    logic            sel_vld;
    logic [1:0]      sel_idx;
    logic            same_sel;
    logic            restart;
    logic            cap_now;
    logic [3:0]      cnt_inc;
    logic [3:0]      cap_code;
    logic [3:0]      sel_bit;
    logic            frame_full;
    logic [6:0]      sec_sum;

    function automatic logic [3:0] seg_decode(input logic [6:0] pat);
        logic [3:0] code;
        case (pat)
            7'h7E:   code = 4'd0;
            7'h30:   code = 4'd1;
            7'h6D:   code = 4'd2;
            7'h79:   code = 4'd3;
            7'h33:   code = 4'd4;
            7'h5B:   code = 4'd5;
            7'h5F:   code = 4'd6;
            7'h70:   code = 4'd7;
            7'h7F:   code = 4'd8;
            7'h7B:   code = 4'd9;
            7'h00:   code = CODE_BLANK;
            default: code = CODE_ERR;
        endcase
        return code;
    endfunction

    // Selects are active-low; anything other than exactly one low line means no digit.
    always_comb begin
        sel_vld = 1'b1;
        sel_idx = 2'd0;
        case (dg_s2)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_vld = 1'b0;
        endcase
    end

    assign same_sel   = (sel_idx == cur_idx) && (seg_s2 == cur_pat);
    assign restart    = sel_vld && ((state == IDLE) || !same_sel);
    assign cnt_inc    = stab_cnt + 4'd1;
    // A freshly loaded pair already counts as one stable cycle, so STABLE_CYC=1 captures at once.
    assign cap_now    = (restart && (STABLE_LIM == 4'd1))
                      || (sel_vld && same_sel && (state == WAIT_STABLE) && (cnt_inc == STABLE_LIM));
    assign cap_code   = seg_decode(seg_s2);
    assign sel_bit    = 4'b0001 << sel_idx;
    assign frame_full = (frame_bits & DIG_MASK) == DIG_MASK;
    assign sec_sum    = 7'(dig[2]) * 7'd10 + 7'(dig[3]);

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            dg_s1  <= 4'hF;
            dg_s2  <= 4'hF;
            seg_s1 <= 7'h00;
            seg_s2 <= 7'h00;
        end else begin
            dg_s1  <= {DG4, DG3, DG2, DG1};
            dg_s2  <= dg_s1;
            seg_s1 <= SEG_IN;
            seg_s2 <= seg_s1;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            state    <= IDLE;
            stab_cnt <= 4'd0;
            cur_idx  <= 2'd0;
            cur_pat  <= 7'h00;
        end else if (!sel_vld) begin
            state    <= IDLE;
            stab_cnt <= 4'd0;
        end else if (restart) begin
            cur_idx  <= sel_idx;
            cur_pat  <= seg_s2;
            stab_cnt <= 4'd1;
            state    <= cap_now ? CAPTURED : WAIT_STABLE;
        end else if (state == WAIT_STABLE) begin
            stab_cnt <= cnt_inc;
            if (cap_now) begin
                state <= CAPTURED;
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            dig        <= {4{CODE_BLANK}};
            dig_vld    <= 4'b0000;
            frame_bits <= 4'b0000;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            sec_bin    <= 7'd0;
            sec_ok     <= 1'b0;
            tmo_cnt    <= 20'd0;
            stale      <= 1'b0;
            cap_d      <= 1'b0;
        end else begin
            cap_d      <= cap_now;
            seg_err    <= 1'b0;
            frame_done <= frame_full;
            if (cap_d) begin
                sec_bin <= sec_sum;
                sec_ok  <= (dig[2] <= 4'd5) && (dig[3] <= 4'd9) && dig_vld[2] && dig_vld[3];
            end
            if (cap_now) begin
                dig[sel_idx] <= cap_code;
                tmo_cnt      <= 20'd0;
                stale        <= 1'b0;
                if (cap_code == CODE_ERR) begin
                    dig_vld[sel_idx] <= 1'b0;
                    seg_err          <= 1'b1;
                    frame_bits       <= frame_full ? 4'b0000 : frame_bits;
                end else begin
                    dig_vld[sel_idx] <= (cap_code != CODE_BLANK);
                    frame_bits       <= (frame_full ? 4'b0000 : frame_bits) | sel_bit;
                end
            end else begin
                if (frame_full) begin
                    frame_bits <= 4'b0000;
                end
                // Saturating timeout; a capture in the same cycle takes priority above.
                if (tmo_cnt != TIMEOUT_LIM) begin
                    tmo_cnt <= tmo_cnt + 20'd1;
                    if ((tmo_cnt + 20'd1) == TIMEOUT_LIM) begin
                        stale   <= 1'b1;
                        dig_vld <= 4'b0000;
                    end
                end
            end
        end
    end

    assign DIG1       = dig[0];
    assign DIG2       = dig[1];
    assign DIG3       = dig[2];
    assign DIG4       = dig[3];
    assign DIG_VLD    = dig_vld;
    assign SEC_BIN    = sec_bin;
    assign SEC_OK     = sec_ok;
    assign FRAME_DONE = frame_done;
    assign SEG_ERR    = seg_err;
    assign STALE      = stale;

endmodule
